mem_port_arbiter: RTL and testbench

//   Shares the CPU's single-ported Memory between two requesters:
//     - instruction fetch (IF port): read only
//     - memory stage (D port): load or store

---
 rtl/tsp16_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsp16_pkg.sv
// Shared definitions for the 16-bit CPU memory subsystem.
//   ADDR_W / DATA_W : default address and data widths
//   arb_state_t     : memory port arbiter state encoding
//   owner_t         : which requester owns the transaction in flight
package tsp16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported Memory between instruction fetch (read only)
// and the memory stage (load/store). Data has priority; a starvation
// counter forces a fetch grant after STARVE_MAX consecutive data grants
// taken while a fetch was waiting.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   if_req/if_addr             fetch request, address held until if_gnt
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, response pulse, held data
//   d_req/d_we/d_addr/d_wdata  data request, fields held until d_gnt
//   d_gnt/d_rvalid/d_rdata     data grant pulse, response pulse, held load data
//   mem_en/mem_we              one-cycle access strobe, qualified write enable
//   mem_addr/mem_wdata         registered access address / write data
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_en
//   busy                       high whenever a transaction is in progress
//
// state     | meaning
// ARB_IDLE  | arbitrating; grant is combinational this cycle
// ARB_ISSUE | mem_en strobe for the captured transaction
// ARB_WAIT  | counting down memory latency; last cycle captures rdata
module mem_port_arbiter #(
  parameter int ADDR_W     = tsp16_pkg::ADDR_W,
  parameter int DATA_W     = tsp16_pkg::DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import tsp16_pkg::*;

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_t       state, state_nxt;
  owner_t           owner;
  logic             cap_we;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             win_d, win_if;
  logic             last_wait;

  assign last_wait = (state == ARB_WAIT) && (lat_cnt == LAT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_d     = 1'b0;
    win_if    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ARB_IDLE: begin
        // fetch overrides data only once it has been passed over STARVE_MAX times
        if (d_req && !(if_req && starve_cnt == STV_W'(STARVE_MAX))) begin
          win_d     = 1'b1;
          state_nxt = ARB_ISSUE;
        end else if (if_req) begin
          win_if    = 1'b1;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = cap_we;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // grants are combinational from the requests; keep them quiet while reset is held
  assign d_gnt  = win_d & ~rst;
  assign if_gnt = win_if & ~rst;
  assign busy   = (state != ARB_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IF;
      cap_we     <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (win_d) begin
        owner     <= OWN_D;
        cap_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt != STV_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + STV_W'(1);
      end else if (win_if) begin
        owner      <= OWN_IF;
        cap_we     <= 1'b0;
        mem_addr   <= if_addr;
        starve_cnt <= '0;
      end

      if (state == ARB_ISSUE)
        lat_cnt <= LAT_W'(MEM_LAT);
      else if (state == ARB_WAIT)
        lat_cnt <= lat_cnt - LAT_W'(1);

      if (last_wait) begin
        if (owner == OWN_D) begin
          d_rvalid <= 1'b1;
          if (!cap_we) d_rdata <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3;
  logic [15:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  // contents of memory locations never written
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0] ^ 8'h5C, a[15:8] ^ 8'hA3};
  endfunction

  // memory devices: latency 1 and latency 3
  logic [15:0] dev1 [logic [15:0]];
  logic [15:0] dev3 [logic [15:0]];
  logic [15:0] p3 [3];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= dev1.exists(mem_addr) ? dev1[mem_addr] : dflt(mem_addr);
      if (mem_we) dev1[mem_addr] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (mem_en_3) begin
      p3[0] <= dev3.exists(mem_addr_3) ? dev3[mem_addr_3] : dflt(mem_addr_3);
      if (mem_we_3) dev3[mem_addr_3] = mem_wdata_3;
    end
  end
  assign mem_rdata_3 = p3[2];

  // reference model memory (transaction level)
  logic [15:0] ref_mem [logic [15:0]];
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_gnts"}, {if_gnt, d_gnt}, 0);
    check({pfx, "_rvalids"}, {if_rvalid, d_rvalid}, 0);
    check({pfx, "_if_rdata"}, if_rdata, 0);
    check({pfx, "_d_rdata"}, d_rdata, 0);
    check({pfx, "_mem_en_we"}, {mem_en, mem_we}, 0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // random-phase model state
  bit          if_pend, d_pend, ph_if, ph_d, win_d, t_we;
  logic [15:0] t_addr, t_wdata;
  bit          exp_if_rv, exp_d_rv;
  logic [15:0] exp_if_rdata, exp_d_rdata;
  int          starve;
  string       exp_order;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    dev1[16'h0010] = 16'hBEEF;
    dev3[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 0;
    tick();

    // lone fetch
    if_req = 1; if_addr = 16'h0010; #1;
    check("s1_if_gnt", if_gnt, 1);
    check("s1_d_gnt", d_gnt, 0);
    check("s1_busy_c0", busy, 0);
    tick(); if_req = 0; if_addr = 16'h7777; #1;
    check("s1_mem_en", {mem_en, mem_we}, 2'b10);
    check("s1_mem_addr", mem_addr, 16'h0010);
    check("s1_busy_c1", busy, 1);
    tick(); #1;
    check("s1_rvalid_c2", if_rvalid, 0);
    check("s1_mem_en_c2", mem_en, 0);
    tick(); #1;
    check("s1_rvalid_c3", if_rvalid, 1);
    check("s1_rdata", if_rdata, 16'hBEEF);
    check("s1_busy_c3", busy, 0);

    // fetch and load together: data wins, fetch follows
    if_req = 1; if_addr = 16'h0044; d_req = 1; d_we = 0; d_addr = 16'h0200; d_wdata = 16'h0; #1;
    check("s2_d_gnt", {d_gnt, if_gnt}, 2'b10);
    tick(); d_req = 0; #1;
    check("s2_if_gnt_c1", if_gnt, 0);
    tick(); #1;
    check("s2_c2", {if_gnt, d_rvalid}, 0);
    tick(); #1;
    check("s2_d_rvalid", d_rvalid, 1);
    check("s2_d_rdata", d_rdata, dflt(16'h0200));
    check("s2_if_gnt_c3", {if_gnt, d_gnt}, 2'b10);
    tick(); if_req = 0; #1;
    tick(); #1;
    tick(); #1;
    check("s2_if_rvalid", if_rvalid, 1);
    check("s2_if_rdata", if_rdata, dflt(16'h0044));

    // store
    d_req = 1; d_we = 1; d_addr = 16'h0300; d_wdata = 16'h1234; #1;
    check("s3_d_gnt", d_gnt, 1);
    tick(); d_req = 0; d_wdata = 16'hFFFF; #1;
    check("s3_mem_en_we", {mem_en, mem_we}, 2'b11);
    check("s3_mem_wdata", mem_wdata, 16'h1234);
    check("s3_mem_addr", mem_addr, 16'h0300);
    tick(); tick(); #1;
    check("s3_d_rvalid", d_rvalid, 1);
    check("s3_d_rdata_kept", d_rdata, dflt(16'h0200));
    ref_mem[16'h0300] = 16'h1234;
    d_we = 0;

    // both held high: starvation rotation
    exp_order = "DDDDIDDDDI";
    if_req = 1; if_addr = 16'h0050; d_req = 1; d_we = 0; d_addr = 16'h0060;
    for (int g = 0; g < 10; g++) begin
      #1;
      check($sformatf("s4_grant_%0d", g), {d_gnt, if_gnt},
            (exp_order[g] == "D") ? 2'b10 : 2'b01);
      tick();
      if (g == 9) begin if_req = 0; d_req = 0; end
      tick(); tick();
    end

    // reset while in WAIT
    if_req = 1; if_addr = 16'h0010; #1;
    check("s5_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick();
    #1 rst = 1;
    #1;
    check_all_zero("s5_rst");
    @(posedge clk);
    #2 rst = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      check($sformatf("s5_no_rvalid_%0d", c), {if_rvalid, d_rvalid, busy}, 0);
    end
    if_req = 1; if_addr = 16'h0010; #1;
    check("s5b_if_gnt", if_gnt, 1);
    tick(); if_req = 0; #1;
    check("s5b_mem", {mem_en, mem_addr}, {1'b1, 16'h0010});
    tick(); tick(); #1;
    check("s5b_rvalid", {if_rvalid, if_rdata}, {1'b1, 16'hBEEF});

    // MEM_LAT=3 back-to-back fetches
    tick(); rst = 1;
    @(posedge clk);
    #2 rst = 0;
    tick();
    if_req = 1; if_addr = 16'h0021; #1;
    check("s6_gnt_c0", if_gnt_3, 1);
    tick(); if_addr = 16'h0022; #1;
    check("s6_mem_c1", {mem_en_3, mem_addr_3}, {1'b1, 16'h0021});
    check("s6_gnt_c1", if_gnt_3, 0);
    for (int c = 2; c < 5; c++) begin
      tick(); #1;
      check($sformatf("s6_quiet_c%0d", c), {if_gnt_3, if_rvalid_3}, 0);
    end
    tick(); #1;
    check("s6_c5", {if_gnt_3, if_rvalid_3}, 2'b11);
    check("s6_rdata0", if_rdata_3, dflt(16'h0021));
    tick(); if_req = 0; #1;
    for (int c = 7; c < 10; c++) begin
      tick(); #1;
      check($sformatf("s6_norv_c%0d", c), if_rvalid_3, 0);
    end
    tick(); #1;
    check("s6_c10", {if_rvalid_3, if_rdata_3}, {1'b1, dflt(16'h0022)});

    // randomized traffic against the transaction-level model
    tick(); rst = 1;
    @(posedge clk);
    #2 rst = 0;
    tick();
    if_pend = 0; d_pend = 0; ph_if = 0; ph_d = 0;
    exp_if_rv = 0; exp_d_rv = 0; exp_if_rdata = 0; exp_d_rdata = 0; starve = 0;
    for (int n = 0; n < 60; n++) begin
      if (ph_if) begin if_req = 0; ph_if = 0; end
      if (ph_d)  begin d_req = 0;  ph_d = 0;  end
      #1;
      check("rnd_rvalid", {if_rvalid, d_rvalid}, {exp_if_rv, exp_d_rv});
      check("rnd_if_rdata", if_rdata, exp_if_rdata);
      check("rnd_d_rdata", d_rdata, exp_d_rdata);
      exp_if_rv = 0; exp_d_rv = 0;

      if (!if_pend && !d_pend && $urandom_range(0, 4) == 0) begin
        check("rnd_gap", {if_gnt, d_gnt, busy}, 0);
        tick();
      end

      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1; if_req = 1; if_addr = 16'h0040 | 16'($urandom_range(0, 15));
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 16'h0040 | 16'($urandom_range(0, 15)); d_wdata = 16'($urandom);
      end
      if (!if_pend && !d_pend) begin
        if_pend = 1; if_req = 1; if_addr = 16'h0040 | 16'($urandom_range(0, 15));
      end
      #1;

      win_d = d_pend && !(if_pend && starve == SMAX);
      check($sformatf("rnd_grant_%0d", n), {d_gnt, if_gnt}, win_d ? 2'b10 : 2'b01);
      if (win_d) begin
        starve = if_pend ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; d_pend = 0;
      end else begin
        starve = 0;
        t_we = 0; t_addr = if_addr; t_wdata = 0; if_pend = 0;
      end

      tick();
      if (win_d) begin
        d_req = 0; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end else begin
        if_req = 0; if_addr = 16'($urandom);
      end
      if (!if_pend && $urandom_range(0, 3) == 0) begin
        ph_if = 1; if_req = 1; if_addr = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        ph_d = 1; d_req = 1; d_addr = 16'($urandom);
      end
      #1;
      check("rnd_issue", {mem_en, mem_we, mem_addr}, {1'b1, t_we, t_addr});
      if (t_we) check("rnd_wdata", mem_wdata, t_wdata);
      check("rnd_issue_quiet", {if_gnt, d_gnt, if_rvalid, d_rvalid}, 0);

      tick(); #1;
      check("rnd_wait", {mem_en, busy, if_gnt, d_gnt}, 4'b0100);

      tick();
      if (win_d) begin
        exp_d_rv = 1;
        if (t_we) ref_mem[t_addr] = t_wdata;
        else      exp_d_rdata = ref_rd(t_addr);
      end else begin
        exp_if_rv = 1;
        exp_if_rdata = ref_rd(t_addr);
      end
    end
    #1;
    check("rnd_final_rvalid", {if_rvalid, d_rvalid}, {exp_if_rv, exp_d_rv});
    check("rnd_final_rdata", {if_rdata, d_rdata}, {exp_if_rdata, exp_d_rdata});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
